// File: rtl/shiftreg_universal.sv
// Universal shift register: DEPTH stages of WIDTH bits with hold / shift right / shift left / parallel load.
// Optional rotate-select port is enabled by defining SHIFTREG_ROTATE_EN.

module shiftreg_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] from_lo,
  input  logic [WIDTH-1:0] from_hi,
  input  logic [WIDTH-1:0] load_w,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (clear) q <= '0;
    else if (en) begin
      case (mode)
        2'b01:   q <= from_lo;
        2'b10:   q <= from_hi;
        2'b11:   q <= load_w;
        default: q <= q;
      endcase
    end
  end
endmodule

module shiftreg_universal #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int FW   = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       sin_r,
  input  logic [WIDTH-1:0]       sin_l,
  input  logic [DEPTH*WIDTH-1:0] pin,
`ifdef SHIFTREG_ROTATE_EN
  input  logic                   rot,
`endif
  output logic [DEPTH*WIDTH-1:0] pout,
  output logic [WIDTH-1:0]       sout_r,
  output logic [WIDTH-1:0]       sout_l,
  output logic [FW-1:0]          fill,
  output logic                   full
);
`ifndef SHIFTREG_ROTATE_EN
  logic rot;
  assign rot = 1'b0;
`endif

  logic [DEPTH-1:0][WIDTH-1:0] q;
  logic [WIDTH-1:0]            head_r, head_l;
  logic [FW-1:0]               fill_nxt;
  logic                        is_shift;

  // Rotate feeds each end from the opposite end's current word.
  assign head_r = rot ? q[DEPTH-1] : sin_r;
  assign head_l = rot ? q[0]       : sin_l;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] lo, hi;
    if (i == 0) begin : g_first
      assign lo = head_r;
    end else begin : g_lo
      assign lo = q[i-1];
    end
    if (i == DEPTH-1) begin : g_last
      assign hi = head_l;
    end else begin : g_hi
      assign hi = q[i+1];
    end
    shiftreg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .clear   (clear),
      .en      (en),
      .mode    (mode),
      .from_lo (lo),
      .from_hi (hi),
      .load_w  (pin[i*WIDTH +: WIDTH]),
      .q       (q[i])
    );
  end

  assign is_shift = (mode == 2'b01) || (mode == 2'b10);

  always_comb begin
    fill_nxt = fill;
    if (mode == 2'b11) fill_nxt = FW'(DEPTH);
    else if (is_shift && !rot && (fill != FW'(DEPTH))) fill_nxt = fill + FW'(1);
  end

  // full is registered alongside fill so both flip on the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      fill <= '0;
      full <= 1'b0;
    end else if (en) begin
      fill <= fill_nxt;
      full <= (fill_nxt == FW'(DEPTH));
    end
  end

  assign pout   = q;
  assign sout_r = q[DEPTH-1];
  assign sout_l = q[0];
endmodule

// File: tb/tb_shiftreg_universal.sv
// Bench for shiftreg_universal (WIDTH=4, DEPTH=4): directed vector table plus randomized run vs an array model.
module tb_shiftreg_universal;
  localparam int W = 4;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          clear, en;
  logic [1:0]    mode;
  logic [W-1:0]  sin_r, sin_l;
  logic [D*W-1:0] pin;
  logic          rot;
  logic [D*W-1:0] pout;
  logic [W-1:0]  sout_r, sout_l;
  logic [2:0]    fill;
  logic          full;

  int checks = 0;
  int passes = 0;

  shiftreg_universal #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .clear(clear), .en(en), .mode(mode),
    .sin_r(sin_r), .sin_l(sin_l), .pin(pin),
`ifdef SHIFTREG_ROTATE_EN
    .rot(rot),
`endif
    .pout(pout), .sout_r(sout_r), .sout_l(sout_l), .fill(fill), .full(full)
  );

  always #5 clk = ~clk;

  // Reference model: word array and a saturating count.
  int unsigned m_q[D];
  int          m_fill;

  function automatic logic [D*W-1:0] m_pout();
    logic [D*W-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i*W +: W] = m_q[i][W-1:0];
    return v;
  endfunction

  function automatic void m_step(logic c, logic e, logic [1:0] m, logic [W-1:0] sr,
                                 logic [W-1:0] sl, logic [D*W-1:0] p, logic r);
    int unsigned old[D];
    logic eff_rot;
    old = m_q;
`ifdef SHIFTREG_ROTATE_EN
    eff_rot = r;
`else
    eff_rot = 1'b0;
`endif
    if (c) begin
      foreach (m_q[i]) m_q[i] = 0;
      m_fill = 0;
    end else if (e) begin
      if (m == 2'b01) begin
        m_q[0] = eff_rot ? old[D-1] : int'(sr);
        for (int i = 1; i < D; i++) m_q[i] = old[i-1];
        if (!eff_rot) m_fill = (m_fill + 1 > D) ? D : m_fill + 1;
      end else if (m == 2'b10) begin
        m_q[D-1] = eff_rot ? old[0] : int'(sl);
        for (int i = 0; i < D-1; i++) m_q[i] = old[i+1];
        if (!eff_rot) m_fill = (m_fill + 1 > D) ? D : m_fill + 1;
      end else if (m == 2'b11) begin
        for (int i = 0; i < D; i++) m_q[i] = int'(p[i*W +: W]);
        m_fill = D;
      end
    end
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply(logic c, logic e, logic [1:0] m, logic [W-1:0] sr,
                       logic [W-1:0] sl, logic [D*W-1:0] p, logic r);
    clear = c; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p; rot = r;
    m_step(c, e, m, sr, sl, p, r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string name, logic [D*W-1:0] ep, int ef);
    check({name, ".pout"},   32'(pout),   32'(ep));
    check({name, ".fill"},   32'(fill),   32'(ef));
    check({name, ".full"},   32'(full),   32'(ef == D));
    check({name, ".sout_r"}, 32'(sout_r), 32'(ep[D*W-1 -: W]));
    check({name, ".sout_l"}, 32'(sout_l), 32'(ep[W-1:0]));
  endtask

  typedef struct {
    string          name;
    logic           clear, en;
    logic [1:0]     mode;
    logic [W-1:0]   sin_r, sin_l;
    logic [D*W-1:0] pin;
    logic [D*W-1:0] exp_pout;
    int             exp_fill;
  } vec_t;

  function automatic vec_t mk(string n, logic c, logic e, logic [1:0] m, logic [W-1:0] sr,
                              logic [W-1:0] sl, logic [D*W-1:0] p, logic [D*W-1:0] ep, int ef);
    vec_t v;
    v.name = n; v.clear = c; v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl;
    v.pin = p; v.exp_pout = ep; v.exp_fill = ef;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    clear = 1'b1; en = 1'b0; mode = 2'b00; sin_r = '0; sin_l = '0; pin = '0; rot = 1'b0;
    foreach (m_q[i]) m_q[i] = 0;
    m_fill = 0;

    // Stage 0 is the low nibble of pout/pin.
    vecs.push_back(mk("rst_arb_load", 0, 1, 2'b11, 0, 0, 16'h5A5A, 16'h5A5A, 4));
    vecs.push_back(mk("rst_clear",    1, 0, 2'b00, 0, 0, 16'h0000, 16'h0000, 0));
    vecs.push_back(mk("rst_over_ld",  1, 1, 2'b11, 0, 0, 16'hFFFF, 16'h0000, 0));
    vecs.push_back(mk("sr1",          0, 1, 2'b01, 1, 0, 16'h0000, 16'h0001, 1));
    vecs.push_back(mk("sr2",          0, 1, 2'b01, 2, 0, 16'h0000, 16'h0012, 2));
    vecs.push_back(mk("sr3",          0, 1, 2'b01, 3, 0, 16'h0000, 16'h0123, 3));
    vecs.push_back(mk("sr4",          0, 1, 2'b01, 4, 0, 16'h0000, 16'h1234, 4));
    vecs.push_back(mk("sr5_sat",      0, 1, 2'b01, 5, 0, 16'h0000, 16'h2345, 4));
    vecs.push_back(mk("ld_abcd",      0, 1, 2'b11, 0, 0, 16'hABCD, 16'hABCD, 4));
    vecs.push_back(mk("sl_e",         0, 1, 2'b10, 0, 4'hE, 16'h0, 16'hEABC, 4));
    vecs.push_back(mk("en0_a",        0, 0, 2'b10, 0, 4'h1, 16'h0, 16'hEABC, 4));
    vecs.push_back(mk("en0_b",        0, 0, 2'b11, 0, 4'h2, 16'hFFFF, 16'hEABC, 4));
    vecs.push_back(mk("en0_c",        0, 0, 2'b01, 4'h3, 0, 16'h0, 16'hEABC, 4));
    vecs.push_back(mk("lp_clear",     1, 1, 2'b01, 0, 0, 16'h0, 16'h0000, 0));
    vecs.push_back(mk("lp_sr9",       0, 1, 2'b01, 9, 0, 16'h0, 16'h0009, 1));
    vecs.push_back(mk("lp_load",      0, 1, 2'b11, 0, 0, 16'h1234, 16'h1234, 4));
    vecs.push_back(mk("mid_clear0",   1, 0, 2'b00, 0, 0, 16'h0, 16'h0000, 0));
    vecs.push_back(mk("mid_sr6",      0, 1, 2'b01, 6, 0, 16'h0, 16'h0006, 1));
    vecs.push_back(mk("mid_sr8",      0, 1, 2'b01, 8, 0, 16'h0, 16'h0068, 2));
    vecs.push_back(mk("mid_clear",    1, 1, 2'b01, 9, 0, 16'h0, 16'h0000, 0));
    vecs.push_back(mk("mid_sr7",      0, 1, 2'b01, 7, 0, 16'h0, 16'h0007, 1));
    vecs.push_back(mk("hold_mode00",  0, 1, 2'b00, 5, 5, 16'hFFFF, 16'h0007, 1));
    vecs.push_back(mk("sl_discard",   0, 1, 2'b10, 0, 3, 16'h0, 16'h3000, 2));

    @(posedge clk); #1;
    foreach (vecs[k]) begin
      apply(vecs[k].clear, vecs[k].en, vecs[k].mode, vecs[k].sin_r, vecs[k].sin_l, vecs[k].pin, 1'b0);
      check_all(vecs[k].name, vecs[k].exp_pout, vecs[k].exp_fill);
    end

    // Latency: a word entering at sin_r reaches sout_r after DEPTH-1 more right shifts.
    apply(1, 0, 2'b00, 0, 0, 0, 0);
    apply(0, 1, 2'b01, 4'hC, 0, 0, 0);
    for (int k = 0; k < D-2; k++) apply(0, 1, 2'b01, 0, 0, 0, 0);
    check("lat_r_early", 32'(sout_r), 32'h0);
    apply(0, 1, 2'b01, 0, 0, 0, 0);
    check("lat_r", 32'(sout_r), 32'hC);

`ifdef SHIFTREG_ROTATE_EN
    apply(0, 1, 2'b11, 0, 0, 16'h1234, 0);
    apply(0, 1, 2'b01, 4'hF, 0, 0, 1);
    check_all("rot_r", 16'h2341, 4);
    apply(0, 1, 2'b10, 0, 4'hF, 0, 1);
    check_all("rot_l", 16'h1234, 4);
    apply(1, 0, 2'b00, 0, 0, 0, 0);
    apply(0, 1, 2'b01, 4'h5, 0, 0, 0);
    apply(0, 1, 2'b01, 4'h9, 4'h9, 0, 1);
    check_all("rot_fill_keep", 16'h0050, 1);
`endif

    // Randomized run against the array model.
    for (int n = 0; n < 600; n++) begin
      logic c, e, r;
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) == 0);
      apply(c, e, 2'($urandom), 4'($urandom), 4'($urandom), 16'($urandom), r);
      check_all($sformatf("rand%0d", n), m_pout(), m_fill);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
